// File: rtl/dram_cmd_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dram_cmd_responder: device-side DRAM model answering the controller bus. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module dram_cmd_responder #(
  parameter int NUMBER_OF_COLUMNS = 8,
  parameter int NUMBER_OF_ROWS    = 128,
  parameter int NUMBER_OF_BANKS   = 8,
  parameter int DRAM_DATA_WIDTH   = 8,
  parameter int CAS_LATENCY       = 2,
  parameter int REFRESH_CYCLES    = 1250,
  parameter int COLUMN_WIDTH      = $clog2(NUMBER_OF_COLUMNS),
  parameter int ROW_WIDTH         = $clog2(NUMBER_OF_ROWS),
  parameter int BANK_ID_WIDTH     = $clog2(NUMBER_OF_BANKS),
  parameter int DRAM_ADDR_WIDTH   = (ROW_WIDTH > COLUMN_WIDTH) ? ROW_WIDTH : COLUMN_WIDTH
) (
  input  logic                       u_clk,
  input  logic                       u_rst,
  input  logic                       dram_cs_n,
  input  logic                       dram_ras_n,
  input  logic                       dram_cas_n,
  input  logic                       dram_we_n,
  input  logic                       dram_clk_en,
  input  logic [DRAM_ADDR_WIDTH-1:0] dram_addr,
  input  logic [BANK_ID_WIDTH-1:0]   dram_bank_id,
  input  logic [DRAM_DATA_WIDTH-1:0] dram_wr_data,
  output logic [DRAM_DATA_WIDTH-1:0] dram_rd_data,
  output logic                       dram_rd_valid,
  output logic [NUMBER_OF_BANKS-1:0] open_bank_mask,
  output logic [4:0]                 err_pulse,
  output logic [4:0]                 err_sticky
);

  localparam logic [2:0] c_CMD_ACT   = 3'b011;
  localparam logic [2:0] c_CMD_PRE   = 3'b010;
  localparam logic [2:0] c_CMD_RD    = 3'b101;
  localparam logic [2:0] c_CMD_WR    = 3'b100;
  localparam logic [2:0] c_CMD_REF   = 3'b001;
  localparam logic [2:0] c_CMD_ILL_A = 3'b000;
  localparam logic [2:0] c_CMD_ILL_B = 3'b110;

  localparam int c_IDX_W     = BANK_ID_WIDTH + ROW_WIDTH + COLUMN_WIDTH;
  localparam int c_MEM_DEPTH = 1 << c_IDX_W;
  localparam int c_REF_CNT_W = $clog2(REFRESH_CYCLES + 1);
  localparam logic [c_REF_CNT_W-1:0] c_REF_LAST = c_REF_CNT_W'(REFRESH_CYCLES - 1);

  logic [NUMBER_OF_BANKS-1:0] r_open_mask;
  logic [ROW_WIDTH-1:0]       r_open_row [NUMBER_OF_BANKS];
  logic [DRAM_DATA_WIDTH-1:0] r_mem [c_MEM_DEPTH];
  logic [DRAM_DATA_WIDTH-1:0] r_rd_word;
  logic [CAS_LATENCY-1:0]     r_valid_pipe;
  logic [c_REF_CNT_W-1:0]     r_ref_cnt;
  logic [4:0]                 r_err_pulse;
  logic [4:0]                 r_err_sticky;

  logic                       w_cmd_valid;
  logic [2:0]                 w_cmd;
  logic                       w_bank_open;
  logic                       w_act, w_pre, w_rd, w_wr, w_ref, w_ill;
  logic                       w_act_ok, w_rd_ok, w_wr_ok;
  logic                       w_deadline;
  logic [4:0]                 w_err;
  logic [c_IDX_W-1:0]         w_idx;
  logic [CAS_LATENCY:0]       w_valid_shift;
  logic [DRAM_DATA_WIDTH-1:0] w_out_data;

  // Commands are ignored while reset is held so no array write can slip in.
  assign w_cmd_valid = dram_clk_en & ~dram_cs_n & ~u_rst;
  assign w_cmd       = {dram_ras_n, dram_cas_n, dram_we_n};
  assign w_bank_open = r_open_mask[dram_bank_id];

  assign w_act = w_cmd_valid & (w_cmd == c_CMD_ACT);
  assign w_pre = w_cmd_valid & (w_cmd == c_CMD_PRE);
  assign w_rd  = w_cmd_valid & (w_cmd == c_CMD_RD);
  assign w_wr  = w_cmd_valid & (w_cmd == c_CMD_WR);
  assign w_ref = w_cmd_valid & (w_cmd == c_CMD_REF);
  assign w_ill = w_cmd_valid & ((w_cmd == c_CMD_ILL_A) | (w_cmd == c_CMD_ILL_B));

  assign w_act_ok = w_act & ~w_bank_open;
  assign w_rd_ok  = w_rd & w_bank_open;
  assign w_wr_ok  = w_wr & w_bank_open;

  // A REFRESH landing on the deadline edge satisfies it.
  assign w_deadline = ~w_ref & (r_ref_cnt == c_REF_LAST);

  assign w_err = {w_ill,
                  w_deadline,
                  w_ref & (|r_open_mask),
                  w_act & w_bank_open,
                  (w_rd | w_wr) & ~w_bank_open};

  assign w_idx = {dram_bank_id, r_open_row[dram_bank_id], dram_addr[COLUMN_WIDTH-1:0]};

  always_ff @(posedge u_clk) begin
    if (u_rst) begin
      r_open_mask <= '0;
    end else begin
      if (w_act_ok) begin
        r_open_mask[dram_bank_id] <= 1'b1;
      end
      if (w_pre) begin
        if (dram_addr[DRAM_ADDR_WIDTH-1]) begin
          r_open_mask <= '0;
        end else begin
          r_open_mask[dram_bank_id] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge u_clk) begin
    if (w_act_ok) begin
      r_open_row[dram_bank_id] <= dram_addr[ROW_WIDTH-1:0];
    end
  end

  // Read-first array: the word captured here is the value before any same-edge write.
  always_ff @(posedge u_clk) begin
    if (w_wr_ok) begin
      r_mem[w_idx] <= dram_wr_data;
    end
    r_rd_word <= r_mem[w_idx];
  end

  assign w_valid_shift = {r_valid_pipe, w_rd_ok};

  always_ff @(posedge u_clk) begin
    if (u_rst) begin
      r_valid_pipe <= '0;
    end else begin
      r_valid_pipe <= w_valid_shift[CAS_LATENCY-1:0];
    end
  end

  generate
    if (CAS_LATENCY == 1) begin : g_lat_direct
      assign w_out_data = r_rd_word;
    end else begin : g_lat_pipe
      logic [DRAM_DATA_WIDTH-1:0] r_data_pipe [CAS_LATENCY-1];
      always_ff @(posedge u_clk) begin
        r_data_pipe[0] <= r_rd_word;
        for (int i = 1; i < CAS_LATENCY - 1; i++) begin
          r_data_pipe[i] <= r_data_pipe[i-1];
        end
      end
      assign w_out_data = r_data_pipe[CAS_LATENCY-2];
    end
  endgenerate

  always_ff @(posedge u_clk) begin
    if (u_rst) begin
      r_ref_cnt <= '0;
    end else if (w_ref || (r_ref_cnt == c_REF_LAST)) begin
      r_ref_cnt <= '0;
    end else begin
      r_ref_cnt <= r_ref_cnt + c_REF_CNT_W'(1);
    end
  end

  always_ff @(posedge u_clk) begin
    if (u_rst) begin
      r_err_pulse  <= '0;
      r_err_sticky <= '0;
    end else begin
      r_err_pulse  <= w_err;
      r_err_sticky <= r_err_sticky | w_err;
    end
  end

  assign dram_rd_valid  = r_valid_pipe[CAS_LATENCY-1];
  assign dram_rd_data   = dram_rd_valid ? w_out_data : '0;
  assign open_bank_mask = r_open_mask;
  assign err_pulse      = r_err_pulse;
  assign err_sticky     = r_err_sticky;

endmodule
`default_nettype wire
